// File: rtl/config_memory_arbiter.sv
// ---------------------------------------------------------------------------
// config_memory_arbiter
//
// Shares the single port of the network configuration memory between
// NUM_REQ requesters. Grants are round-robin, one access per cycle, fully
// pipelined. A requester may lock the port for an uninterrupted multi-word
// update; a lock whose owner sits idle too long is forcibly released.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid/we/lock   per-requester request, write flag, hold-port flag
//   req_addr/req_wdata  packed per-requester address / write data
//   req_ready           one-hot combinational grant
//   rsp_valid           one-hot read-data strobe
//   rsp_rdata           read data shared by all requesters
//   mem_en/we/addr/din  registered memory port controls
//   mem_dout            memory read data (READ_LATENCY after mem_en)
//   locked, lock_owner  lock status
//   lock_timeout        one-cycle pulse in the cycle of a forced release
// ---------------------------------------------------------------------------
module config_memory_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_din,
    input  logic [DATA_WIDTH-1:0]            mem_dout,
    output logic                             locked,
    output logic [2:0]                       lock_owner,
    output logic                             lock_timeout
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // ---------------- state ----------------
    lock_state_e             lock_state_q, lock_state_d;
    logic [2:0]              owner_q, owner_d;
    logic [CNT_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic [2:0]              ptr_q, ptr_d;

    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
    // One-hot id of the read issued alongside mem_en (zero for writes/idle).
    logic [NUM_REQ-1:0]      iss_rd_id_q, iss_rd_id_d;
    logic [NUM_REQ-1:0]      rd_pipe_q [READ_LATENCY];
    logic [NUM_REQ-1:0]      rd_pipe_d [READ_LATENCY];
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // ---------------- combinational helpers ----------------
    logic                    owner_valid;
    logic                    owner_lock;
    logic                    grant_found;
    logic [2:0]              win_idx;
    logic                    win_we;
    logic                    win_lock;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic                    handshake;
    logic                    lock_timeout_c;

    // Current lock owner's request lines.
    always_comb begin
        owner_valid = 1'b0;
        owner_lock  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == owner_q) begin
                owner_valid = req_valid[i];
                owner_lock  = req_lock[i];
            end
        end
    end

    // Winner selection. While locked only the owner is eligible; otherwise
    // search from ptr upward, then wrap to the indices below ptr.
    always_comb begin
        grant_found = 1'b0;
        win_idx     = '0;
        if (lock_state_q == LOCKED) begin
            grant_found = owner_valid;
            win_idx     = owner_q;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req_valid[i] && (i >= int'(ptr_q))) begin
                    grant_found = 1'b1;
                    win_idx     = 3'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req_valid[i] && (i < int'(ptr_q))) begin
                    grant_found = 1'b1;
                    win_idx     = 3'(i);
                end
            end
        end
    end

    // Winner's request fields and the one-hot grant.
    always_comb begin
        win_we    = 1'b0;
        win_lock  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == win_idx) begin
                win_we       = req_we[i];
                win_lock     = req_lock[i];
                win_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = grant_found;
            end
        end
    end

    // A grant is only ever given to a valid requester, so a grant is a handshake.
    assign handshake = grant_found;

    // Lock FSM and round-robin pointer.
    always_comb begin
        lock_state_d   = lock_state_q;
        owner_d        = owner_q;
        idle_cnt_d     = idle_cnt_q;
        lock_timeout_c = 1'b0;
        ptr_d          = ptr_q;

        if (handshake) begin
            ptr_d = (int'(win_idx) == NUM_REQ - 1) ? 3'd0 : win_idx + 3'd1;
        end

        case (lock_state_q)
            UNLOCKED: begin
                idle_cnt_d = '0;
                if (handshake && win_lock) begin
                    lock_state_d = LOCKED;
                    owner_d      = win_idx;
                end
            end
            LOCKED: begin
                if (handshake) begin
                    idle_cnt_d = '0;
                    if (!win_lock) begin
                        lock_state_d = UNLOCKED;
                        owner_d      = '0;
                    end
                end else if (!owner_lock) begin
                    // Owner neither requesting nor holding: give the port back.
                    lock_state_d = UNLOCKED;
                    owner_d      = '0;
                    idle_cnt_d   = '0;
                end else if (idle_cnt_q == IDLE_MAX) begin
                    lock_timeout_c = 1'b1;
                    lock_state_d   = UNLOCKED;
                    owner_d        = '0;
                    idle_cnt_d     = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                lock_state_d = UNLOCKED;
                owner_d      = '0;
                idle_cnt_d   = '0;
            end
        endcase
    end

    // Memory issue and read-return pipeline.
    always_comb begin
        mem_en_d    = handshake;
        mem_we_d    = handshake & win_we;
        mem_addr_d  = handshake ? win_addr : mem_addr_q;
        mem_din_d   = handshake ? win_wdata : mem_din_q;
        iss_rd_id_d = (handshake && !win_we) ? req_ready : '0;

        // Entry k is aligned with the cycle in which mem_dout for that read
        // becomes valid once it reaches the last stage.
        rd_pipe_d[0] = iss_rd_id_q;
        for (int k = 1; k < READ_LATENCY; k++) begin
            rd_pipe_d[k] = rd_pipe_q[k-1];
        end

        rsp_valid_d = rd_pipe_q[READ_LATENCY-1];
        rsp_rdata_d = (|rd_pipe_q[READ_LATENCY-1]) ? mem_dout : rsp_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_q <= UNLOCKED;
            owner_q      <= '0;
            idle_cnt_q   <= '0;
            ptr_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            iss_rd_id_q  <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_pipe_q[k] <= '0;
            end
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            owner_q      <= owner_d;
            idle_cnt_q   <= idle_cnt_d;
            ptr_q        <= ptr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            iss_rd_id_q  <= iss_rd_id_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_pipe_q[k] <= rd_pipe_d[k];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign locked       = (lock_state_q == LOCKED);
    assign lock_owner   = owner_q;
    assign lock_timeout = lock_timeout_c;

endmodule

// File: tb/tb_config_memory_arbiter.sv
module tb_config_memory_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NR-1:0]      req_valid, req_we, req_lock;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_en, mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_din;
    logic [DW-1:0]      mem_dout;
    logic               locked;
    logic [2:0]         lock_owner;
    logic               lock_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [1024];

    config_memory_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_LATENCY(1), .LOCK_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout),
        .locked(locked), .lock_owner(lock_owner), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] ready;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
    endtask

    task automatic drive(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_lock[i]           = lk;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        clr();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_en"},       64'(mem_en), 64'(0));
        chk({tag, "_mem_we"},       64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"},     64'(mem_addr), 64'(0));
        chk({tag, "_mem_din"},      64'(mem_din), 64'(0));
        chk({tag, "_rsp_valid"},    64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_rdata"},    64'(rsp_rdata), 64'(0));
        chk({tag, "_locked"},       64'(locked), 64'(0));
        chk({tag, "_lock_owner"},   64'(lock_owner), 64'(0));
        chk({tag, "_lock_timeout"}, 64'(lock_timeout), 64'(0));
        chk({tag, "_req_ready"},    64'(req_ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] prev_ready;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[3] = 32'h0a0300ff;

        // Round-robin vectors starting from ptr=0; each row's grant moves ptr.
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100};  // ptr -> 3
        tbl[2]  = '{4'b0101, 4'b0001};  // ptr -> 1
        tbl[3]  = '{4'b1111, 4'b0010};  // ptr -> 2
        tbl[4]  = '{4'b1111, 4'b0100};  // ptr -> 3
        tbl[5]  = '{4'b1111, 4'b1000};  // ptr -> 0
        tbl[6]  = '{4'b1111, 4'b0001};  // ptr -> 1
        tbl[7]  = '{4'b1001, 4'b1000};  // ptr -> 0
        tbl[8]  = '{4'b0110, 4'b0010};  // ptr -> 2
        tbl[9]  = '{4'b0010, 4'b0010};  // wrap search, ptr -> 2
        tbl[10] = '{4'b1000, 4'b1000};  // ptr -> 0

        req_addr  = '0;
        req_wdata = '0;
        reset_n   = 1'b0;
        clr();
        tick();
        tick();
        chk_idle_outputs("in_reset");
        reset_n = 1'b1;
        tick();
        chk_idle_outputs("after_reset");

        // Table-driven round-robin grants with issue check one cycle later.
        prev_ready = '0;
        for (int r = 0; r < 11; r++) begin
            tick();
            clr();
            for (int i = 0; i < NR; i++)
                if (tbl[r].valid[i]) drive(i, 1'b1, 1'b0, 1'b0, 10'(32'h100 + i), '0);
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].ready));
            chk($sformatf("tbl%0d_mem_en", r), 64'(mem_en), 64'(|prev_ready));
            if (|prev_ready)
                chk($sformatf("tbl%0d_mem_addr", r), 64'(mem_addr),
                    64'(32'h100 + oh2i(prev_ready)));
            prev_ready = tbl[r].ready;
        end
        tick();
        clr();
        repeat (3) tick();

        // Read latency: requester 1 reads 0x003.
        clr();
        drive(1, 1'b1, 1'b0, 1'b0, 10'h003, '0);
        #1;
        chk("rd_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        clr();
        #1;
        chk("rd_n1_mem_en", 64'(mem_en), 64'(1));
        chk("rd_n1_mem_we", 64'(mem_we), 64'(0));
        chk("rd_n1_mem_addr", 64'(mem_addr), 64'(10'h003));
        chk("rd_n1_rsp_valid", 64'(rsp_valid), 64'(0));
        tick();
        #1;
        chk("rd_n2_rsp_valid", 64'(rsp_valid), 64'(0));
        tick();
        #1;
        chk("rd_n3_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        chk("rd_n3_rsp_rdata", 64'(rsp_rdata), 64'(32'h0a0300ff));
        tick();
        #1;
        chk("rd_n4_rsp_valid", 64'(rsp_valid), 64'(0));

        // Round-robin: all four requesters for 8 cycles from ptr=0.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            clr();
            for (int i = 0; i < NR; i++) drive(i, 1'b1, 1'b0, 1'b0, 10'(32'h200 + i), '0);
            #1;
            chk($sformatf("rr%0d_ready", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
            if (c > 0) chk($sformatf("rr%0d_mem_en", c), 64'(mem_en), 64'(1));
        end
        tick();
        clr();
        #1;
        chk("rr_last_mem_en", 64'(mem_en), 64'(1));
        chk("rr_last_mem_addr", 64'(mem_addr), 64'(10'h203));

        // Move ptr to 3 with a single write from requester 2.
        tick();
        clr();
        drive(2, 1'b1, 1'b1, 1'b0, 10'h020, 32'h00001234);
        #1;
        chk("pre_lock_ready", 64'(req_ready), 64'(4'b0100));

        // Lock burst: requester 3 writes 0x008..0x00D while 0 and 1 also request.
        for (int k = 0; k < 6; k++) begin
            tick();
            clr();
            drive(0, 1'b1, 1'b0, 1'b0, 10'h040, '0);
            drive(1, 1'b1, 1'b0, 1'b0, 10'h041, '0);
            drive(3, 1'b1, 1'b1, (k < 5), 10'(8 + k), 32'hC0DE0000 + 32'(k));
            #1;
            chk($sformatf("burst%0d_ready", k), 64'(req_ready), 64'(4'b1000));
            chk($sformatf("burst%0d_mem_en", k), 64'(mem_en), 64'(1));
            if (k == 0) begin
                chk("burst0_locked", 64'(locked), 64'(0));
            end else begin
                chk($sformatf("burst%0d_locked", k), 64'(locked), 64'(1));
                chk($sformatf("burst%0d_owner", k), 64'(lock_owner), 64'(3));
                chk($sformatf("burst%0d_mem_we", k), 64'(mem_we), 64'(1));
            end
        end
        tick();
        clr();
        drive(0, 1'b1, 1'b0, 1'b0, 10'h040, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'h041, '0);
        #1;
        chk("post_burst_ready", 64'(req_ready), 64'(4'b0001));
        chk("post_burst_locked", 64'(locked), 64'(0));
        chk("post_burst_owner", 64'(lock_owner), 64'(0));
        chk("post_burst_mem_addr", 64'(mem_addr), 64'(10'h00D));
        chk("post_burst_mem_din", 64'(mem_din), 64'(32'hC0DE0005));
        tick();
        clr();
        tick();
        for (int k = 0; k < 6; k++)
            chk($sformatf("burst_mem%0d", k), 64'(mem[8 + k]), 64'(32'hC0DE0000 + 32'(k)));

        // Lock timeout: requester 2 locks then idles while holding req_lock.
        tick();
        clr();
        drive(2, 1'b1, 1'b0, 1'b1, 10'h050, '0);
        #1;
        chk("to_lock_ready", 64'(req_ready), 64'(4'b0100));
        for (int k = 1; k <= 4; k++) begin
            tick();
            clr();
            drive(2, 1'b0, 1'b0, 1'b1, 10'h050, '0);
            drive(0, 1'b1, 1'b0, 1'b0, 10'h060, '0);
            #1;
            chk($sformatf("to_idle%0d_ready", k), 64'(req_ready), 64'(0));
            chk($sformatf("to_idle%0d_locked", k), 64'(locked), 64'(1));
            chk($sformatf("to_idle%0d_owner", k), 64'(lock_owner), 64'(2));
            chk($sformatf("to_idle%0d_pulse", k), 64'(lock_timeout), 64'(k == 4));
        end
        tick();
        #1;
        chk("to_after_ready", 64'(req_ready), 64'(4'b0001));
        chk("to_after_locked", 64'(locked), 64'(0));
        chk("to_after_pulse", 64'(lock_timeout), 64'(0));

        // Reset mid-operation: locking read by requester 1, then reset.
        tick();
        clr();
        drive(1, 1'b1, 1'b0, 1'b1, 10'h003, '0);
        #1;
        chk("mid_rd_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        clr();
        #1;
        chk("mid_locked_before", 64'(locked), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_locked_in_reset", 64'(locked), 64'(0));
        chk("mid_mem_en_in_reset", 64'(mem_en), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            chk($sformatf("mid_no_rsp%0d", c), 64'(rsp_valid), 64'(0));
            chk($sformatf("mid_unlocked%0d", c), 64'(locked), 64'(0));
        end
        tick();
        clr();
        for (int i = 0; i < NR; i++) drive(i, 1'b1, 1'b0, 1'b0, 10'(32'h300 + i), '0);
        #1;
        chk("mid_first_grant", 64'(req_ready), 64'(4'b0001));
        tick();
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/config_memory_arbiter.md
# config_memory_arbiter

Shares the single port of the 1024 x 32 network configuration memory between up to NUM_REQ requesters, e.g. the boot-time config loader, the UDP command handler and a debug port. Arbitration is round-robin with one access per cycle and full pipelining. A requester may lock the port to perform an uninterrupted multi-word update, such as the six words of one interface's IP/netmask/gateway/target/MAC set. An idle-lock timeout prevents a stuck requester from starving the others.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 10: memory address width.
- DATA_WIDTH, 32: memory data width.
- READ_LATENCY, 1: memory read latency, in cycles from a registered mem_en to a valid mem_dout (1 or 2).
- LOCK_TIMEOUT, 1024: number of consecutive idle cycles of the lock owner after which the lock is forcibly released (>= 2).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  hold the port after this access.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; requester i occupies [i*AW +: AW].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters.
- mem_en, mem_we  out  1  memory port controls.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data.
- locked  out  1  a lock is currently held.
- lock_owner  out  3  index of the lock owner (0 when no lock is held).
- lock_timeout  out  1  one-cycle pulse on a forced lock release.

## Operation
- Grant logic:
  - req_ready is combinational from req_valid, the round-robin pointer and the lock state.
  - At most one bit of req_ready is high per cycle.
  - req_ready is 0 for requesters whose req_valid is low.
- Round-robin:
  - The winner is the lowest index >= ptr with req_valid high, searching with wrap-around.
  - After each handshake, ptr becomes winner+1 mod NUM_REQ.
  - ptr resets to 0.
- Lock states: UNLOCKED and LOCKED(owner).
  - UNLOCKED -> LOCKED: on a handshake with req_lock=1. The owner is the winner.
  - While LOCKED, only the owner can receive a grant; other requesters see req_ready=0. The owner's req_lock is sampled again at every handshake.
  - LOCKED -> UNLOCKED (normal release): on an owner handshake with req_lock=0. That access is still performed.
  - LOCKED -> UNLOCKED (idle release): when the owner has req_valid=0 and req_lock=0 for one cycle.
  - While LOCKED, idle_cnt increments on every cycle in which the owner has req_valid=0, and clears on an owner handshake.
  - LOCKED -> UNLOCKED (forced release): when idle_cnt reaches LOCK_TIMEOUT-1. lock_timeout pulses in that cycle and idle_cnt is cleared.
  - ptr is not altered by any lock release.
- Memory issue:
  - A handshake registers mem_en=1, mem_we=req_we, mem_addr and mem_din on the next edge.
  - With no handshake, mem_en=0 and mem_we=0; mem_addr and mem_din hold their values.
- Read return:
  - A READ_LATENCY-deep shift register carries {valid, one-hot id} for each read.
  - When an entry emerges, rsp_valid is registered with its id and rsp_rdata with mem_dout.
  - Writes generate no response.
- Reads and writes from different requesters may be interleaved back-to-back without bubbles. Responses are delivered in issue order.
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - mem_en, mem_we, mem_addr, mem_din, rsp_valid, rsp_rdata, locked, lock_owner and lock_timeout all reset to 0.
  - The shift register, ptr and idle_cnt are cleared.
  - In-flight reads are dropped without a response.

## Timing
- Handshake in cycle N -> mem_en high in cycle N+1.
- Read: rsp_valid high in cycle N+1+READ_LATENCY+1; this is 3 cycles for READ_LATENCY=1.
- Throughput: 1 access per cycle, sustained.
- The lock takes effect in the cycle after the locking handshake; other requesters cannot be granted in N+1.
- A forced release in cycle T allows another requester to be granted in T+1.
- A simultaneous owner handshake with req_lock=0 and an idle condition cannot both occur, because the idle condition requires req_valid=0.

## Test plan
- Reset values: hold reset_n low, then release -> all outputs are 0 and req_ready=0 with no requests. Asserting req_valid[2] alone gives req_ready=4'b0100 in the same cycle.
- Read latency: requester 1 reads address 0x003, where mem holds 0x0a0300ff, with READ_LATENCY=1 -> mem_en/mem_addr=0x003 in N+1, rsp_valid=4'b0010 and rsp_rdata=0x0a0300ff in N+3.
- Round-robin: all 4 requesters hold req_valid for 8 cycles starting with ptr=0 -> grant order 0,1,2,3,0,1,2,3 and mem_en high continuously.
- Lock burst: requester 3 writes 6 words to 0x008..0x00D with req_lock=1 on the first 5 and 0 on the last, while requesters 0 and 1 are also requesting -> the 6 writes are consecutive, locked=1 and lock_owner=3 throughout, and requester 0 is granted on the cycle after the last write.
- Lock timeout with LOCK_TIMEOUT=4: requester 2 locks, then holds req_valid=0 and req_lock=1 -> lock_timeout pulses on the 4th idle cycle, and a pending requester 0 is granted on the next cycle.
- Reset mid-operation: assert reset_n low one cycle after a read handshake -> no rsp_valid ever appears, locked=0, and after release the first grant follows ptr=0.
